// File: rtl/i2c_slave_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_if
// Bus-side and data-side signals of the I2C target.
//   scl, sda_in : bus clock and sampled SDA line (from the bus)
//   sda_oe      : 1 = target pulls SDA low, 0 = released
//   tx_data     : byte offered for the next read byte (from register bank)
//   rx_data     : last byte written by the bus master
//   rx_valid    : 1-clk pulse when rx_data updates
//   tx_done     : 1-clk pulse when the master ACK/NACK of a sent byte is seen
//   addr_match  : own address acknowledged, cleared by STOP / repeated START
//   rw          : latched R/W bit of the current transfer (1 = read)
//   busy        : bus is between START and STOP
// Modports: slave (the target itself), master (the bus / bank side driving it).
// ----------------------------------------------------------------------------
interface i2c_slave_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_done;
    logic       addr_match;
    logic       rw;
    logic       busy;

    modport slave (
        input  scl, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_done, addr_match, rw, busy
    );

    modport master (
        output scl, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_done, addr_match, rw, busy
    );
endinterface

// File: rtl/i2c_slave.sv
// ----------------------------------------------------------------------------
// i2c_slave
// 7-bit-address I2C target. SCL/SDA are oversampled by clk (>= 8x SCL),
// START/STOP are detected, the own address is ACKed, then write bytes are
// received into rx_data or read bytes are shifted out of tx_data. SDA is
// driven open-drain through sda_oe. No clock stretching.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : i2c_slave_if.slave (scl, sda_in, sda_oe, tx_data, rx_data,
//           rx_valid, tx_done, addr_match, rw, busy)
// ----------------------------------------------------------------------------
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        reset,
    i2c_slave_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_DATA   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_DATA   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_e;

    // Synchroniser / edge-detector flops carry no reset: they keep tracking
    // the real pins through a reset, so deasserting reset can never fake an
    // edge (and hence a START) on a line that is already low.
    logic scl_meta_r, scl_sync_r, scl_prev_r;
    logic sda_meta_r, sda_sync_r, sda_prev_r;

    state_e     state_r, state_n;
    logic [2:0] cnt_r, cnt_n;
    logic [7:0] shift_r, shift_n;
    logic       sda_oe_r, sda_oe_n;
    logic [7:0] rx_data_r, rx_data_n;
    logic       rx_valid_r, rx_valid_n;
    logic       tx_done_r, tx_done_n;
    logic       addr_match_r, addr_match_n;
    logic       rw_r, rw_n;
    logic       busy_r, busy_n;

    logic       scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0] shift_in_s;

    // Two-flop synchronisers followed by one edge-detect flop per line.
    always_ff @(posedge clk) begin
        scl_meta_r <= bus.scl;
        scl_sync_r <= scl_meta_r;
        scl_prev_r <= scl_sync_r;
        sda_meta_r <= bus.sda_in;
        sda_sync_r <= sda_meta_r;
        sda_prev_r <= sda_sync_r;
    end

    assign scl_rise_s = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r & scl_prev_r;
    // SDA moving while SCL is steadily high is a bus condition, not data.
    assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
    assign shift_in_s = {shift_r[6:0], sda_sync_r};

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 3'd0;
            shift_r      <= 8'h00;
            sda_oe_r     <= 1'b0;
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            tx_done_r    <= 1'b0;
            addr_match_r <= 1'b0;
            rw_r         <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            shift_r      <= shift_n;
            sda_oe_r     <= sda_oe_n;
            rx_data_r    <= rx_data_n;
            rx_valid_r   <= rx_valid_n;
            tx_done_r    <= tx_done_n;
            addr_match_r <= addr_match_n;
            rw_r         <= rw_n;
            busy_r       <= busy_n;
        end
    end

    // Next-state and next-output logic; bus conditions take priority over bits.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        shift_n      = shift_r;
        sda_oe_n     = sda_oe_r;
        rx_data_n    = rx_data_r;
        rx_valid_n   = 1'b0;
        tx_done_n    = 1'b0;
        addr_match_n = addr_match_r;
        rw_n         = rw_r;
        busy_n       = busy_r;

        if (start_s) begin
            state_n      = ST_ADDR;
            cnt_n        = 3'd0;
            addr_match_n = 1'b0;
            sda_oe_n     = 1'b0;
            busy_n       = 1'b1;
        end else if (stop_s) begin
            state_n      = ST_IDLE;
            cnt_n        = 3'd0;
            addr_match_n = 1'b0;
            sda_oe_n     = 1'b0;
            busy_n       = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_n = shift_in_s;
                        cnt_n   = cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            // shift_r[6:0] holds the seven address bits here.
                            rw_n = sda_sync_r;
                            if (shift_r[6:0] == SLAVE_ADDR) begin
                                state_n      = ST_ADDR_ACK;
                                addr_match_n = 1'b1;
                            end else begin
                                state_n = ST_WAIT_STOP;
                            end
                        end else begin
                            state_n = ST_ADDR;
                        end
                    end else begin
                        state_n = ST_ADDR;
                    end
                end
                // In both ACK states sda_oe_r tells the two falls apart:
                // first fall starts driving the ACK, second one ends it.
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        if (!sda_oe_r) begin
                            sda_oe_n = 1'b1;
                        end else if (rw_r) begin
                            shift_n  = bus.tx_data;
                            sda_oe_n = ~bus.tx_data[7];
                            cnt_n    = 3'd0;
                            state_n  = ST_TX_DATA;
                        end else begin
                            sda_oe_n = 1'b0;
                            cnt_n    = 3'd0;
                            state_n  = ST_RX_DATA;
                        end
                    end else begin
                        state_n = ST_ADDR_ACK;
                    end
                end
                ST_RX_DATA: begin
                    if (scl_rise_s) begin
                        shift_n = shift_in_s;
                        cnt_n   = cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            rx_data_n  = shift_in_s;
                            rx_valid_n = 1'b1;
                            state_n    = ST_RX_ACK;
                        end else begin
                            state_n = ST_RX_DATA;
                        end
                    end else begin
                        state_n = ST_RX_DATA;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall_s) begin
                        if (!sda_oe_r) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_RX_DATA;
                        end
                    end else begin
                        state_n = ST_RX_ACK;
                    end
                end
                // shift_r[7] is the bit currently on the line.
                ST_TX_DATA: begin
                    if (scl_fall_s) begin
                        cnt_n = cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_TX_ACK;
                        end else begin
                            shift_n  = {shift_r[6:0], 1'b0};
                            sda_oe_n = ~shift_r[6];
                        end
                    end else begin
                        state_n = ST_TX_DATA;
                    end
                end
                // A NACK leaves on the rise, so any fall seen here follows an ACK.
                ST_TX_ACK: begin
                    if (scl_rise_s) begin
                        tx_done_n = 1'b1;
                        if (sda_sync_r) begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_WAIT_STOP;
                        end else begin
                            state_n = ST_TX_ACK;
                        end
                    end else if (scl_fall_s) begin
                        shift_n  = bus.tx_data;
                        sda_oe_n = ~bus.tx_data[7];
                        cnt_n    = 3'd0;
                        state_n  = ST_TX_DATA;
                    end else begin
                        state_n = ST_TX_ACK;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    state_n = state_r;
                end
                default: begin
                    state_n  = ST_IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe     = sda_oe_r;
    assign bus.rx_data    = rx_data_r;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.tx_done    = tx_done_r;
    assign bus.addr_match = addr_match_r;
    assign bus.rw         = rw_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_i2c_slave.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave
// Bit-banged I2C master driving i2c_slave through i2c_slave_if. A table of
// transactions with constant expectations, randomized transactions checked
// against a transaction-level model, and hand sequences for repeated START,
// reset mid-address and STOP mid-byte.
// ----------------------------------------------------------------------------
module tb_i2c_slave;
    localparam int         Q   = 10;     // clk cycles per quarter SCL period
    localparam logic [6:0] OWN = 7'h50;

    typedef struct packed {
        logic [6:0]      addr;
        logic            rd;
        int              n;
        logic [2:0][7:0] d;       // write bytes, or tx_data per read byte
        logic            exp_ack;
        int              exp_rx;
        logic [7:0]      exp_last;
        int              exp_tx;
        logic [2:0][7:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic m_sda;
    always #5 clk = ~clk;

    i2c_slave_if bus();
    assign bus.sda_in = m_sda & ~bus.sda_oe;   // wired-AND open-drain line

    i2c_slave #(.SLAVE_ADDR(OWN)) dut (.clk(clk), .reset(reset), .bus(bus));

    int         checks   = 0;
    int         failures = 0;
    int         rx_cnt   = 0;
    int         tx_cnt   = 0;
    int         oe_cnt   = 0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_cnt = rx_cnt + 1;
            rx_log.push_back(bus.rx_data);
        end
        if (bus.tx_done) tx_cnt = tx_cnt + 1;
        if (bus.sda_oe)  oe_cnt = oe_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        m_sda = b;   wait_q();
        bus.scl = 1'b1; wait_q();
        r = bus.sda_in; wait_q();
        bus.scl = 1'b0; wait_q();
    endtask

    task automatic start_cond();
        m_sda = 1'b1;   wait_q();
        bus.scl = 1'b1; wait_q();
        m_sda = 1'b0;   wait_q();
        bus.scl = 1'b0; wait_q();
    endtask

    task automatic stop_cond();
        m_sda = 1'b0;   wait_q();
        bus.scl = 1'b1; wait_q();
        m_sda = 1'b1;   wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(v[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    // next_tx is presented once the current byte is under way, so the slave
    // has to resample tx_data at the following reload.
    task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            v[i] = r;
            if (i == 7) bus.tx_data = next_tx;
        end
        bit_xfer(nack, r);
    endtask

    function automatic vec_t mk(input logic [6:0] a, input logic rd, input int n,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic ack, input int rx, input logic [7:0] last,
                                input int tx, input logic [7:0] r0, input logic [7:0] r1);
        vec_t v;
        v.addr = a; v.rd = rd; v.n = n;
        v.d = {8'h00, d1, d0};
        v.exp_ack = ack; v.exp_rx = rx; v.exp_last = last; v.exp_tx = tx;
        v.exp_rd = {8'hFF, r1, r0};
        return v;
    endfunction

    // Transaction-level reference: only a matching address is served; a write
    // leaves its last byte in rx_data, a read returns the offered bytes and an
    // idle (released, all-ones) line otherwise.
    function automatic vec_t model(input vec_t v, input logic [7:0] last);
        vec_t e = v;
        e.exp_ack  = (v.addr == OWN);
        e.exp_rx   = (e.exp_ack && !v.rd) ? v.n : 0;
        e.exp_tx   = (e.exp_ack && v.rd) ? v.n : 0;
        e.exp_last = (e.exp_ack && !v.rd) ? v.d[v.n - 1] : last;
        for (int k = 0; k < 3; k++) e.exp_rd[k] = e.exp_ack ? v.d[k] : 8'hFF;
        return e;
    endfunction

    task automatic run_xact(input vec_t v);
        int         base_rx = rx_cnt;
        int         base_tx = tx_cnt;
        int         base_oe = oe_cnt;
        logic       ack;
        logic [7:0] got, nxt;
        if (v.rd) bus.tx_data = v.d[0];
        start_cond();
        write_byte({v.addr, v.rd}, ack);
        check("addr_ack", ack, v.exp_ack);
        check("addr_match", bus.addr_match, v.exp_ack);
        check("busy_in_xfer", bus.busy, 1);
        check("rw_latch", bus.rw, v.rd);
        for (int k = 0; k < v.n; k++) begin
            if (v.rd) begin
                nxt = (k + 1 < v.n) ? v.d[k + 1] : 8'h00;
                read_byte(k == v.n - 1, nxt, got);
                check("rd_byte", got, v.exp_rd[k]);
            end else begin
                write_byte(v.d[k], ack);
                check("data_ack", ack, v.exp_ack);
            end
        end
        stop_cond();
        check("busy_after_stop", bus.busy, 0);
        check("match_after_stop", bus.addr_match, 0);
        check("oe_after_stop", bus.sda_oe, 0);
        check("rx_valid_count", rx_cnt - base_rx, v.exp_rx);
        check("tx_done_count", tx_cnt - base_tx, v.exp_tx);
        check("rx_data", bus.rx_data, v.exp_last);
        for (int k = 0; k < v.exp_rx; k++)
            check("rx_seq", (base_rx + k < rx_log.size()) ? rx_log[base_rx + k] : 8'hXX, v.d[k]);
        if (!v.exp_ack) check("oe_never", oe_cnt - base_oe, 0);
    endtask

    vec_t       vecs[6];
    vec_t       rv;
    logic [7:0] last;
    logic       ack, r;
    logic [7:0] g0, g1;
    int         base_rx, base_tx, base_oe;

    initial begin
        vecs[0] = mk(7'h50, 1'b0, 1, 8'hA5, 8'h00, 1'b1, 1, 8'hA5, 0, 8'hFF, 8'hFF);
        vecs[1] = mk(7'h51, 1'b0, 1, 8'hFF, 8'h00, 1'b0, 0, 8'hA5, 0, 8'hFF, 8'hFF);
        vecs[2] = mk(7'h50, 1'b1, 1, 8'h3C, 8'h00, 1'b1, 0, 8'hA5, 1, 8'h3C, 8'hFF);
        vecs[3] = mk(7'h50, 1'b0, 2, 8'h11, 8'h22, 1'b1, 2, 8'h22, 0, 8'hFF, 8'hFF);
        vecs[4] = mk(7'h50, 1'b1, 2, 8'h5A, 8'hC3, 1'b1, 0, 8'h22, 2, 8'h5A, 8'hC3);
        vecs[5] = mk(7'h28, 1'b1, 1, 8'h77, 8'h00, 1'b0, 0, 8'h22, 0, 8'hFF, 8'hFF);

        reset = 1'b1; bus.scl = 1'b1; m_sda = 1'b1; bus.tx_data = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_tx_done", bus.tx_done, 0);
        check("rst_addr_match", bus.addr_match, 0);
        check("rst_rw", bus.rw, 0);
        check("rst_busy", bus.busy, 0);

        for (int i = 0; i < 6; i++) run_xact(vecs[i]);
        last = 8'h22;

        for (int i = 0; i < 16; i++) begin
            rv.addr = ($urandom_range(0, 1) == 1) ? OWN : 7'($urandom_range(0, 127));
            rv.rd   = 1'($urandom_range(0, 1));
            rv.n    = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) rv.d[k] = 8'($urandom);
            rv = model(rv, last);
            run_xact(rv);
            last = rv.exp_last;
        end

        // Write 0x11,0x22, repeated START, read two bytes (ACK then NACK).
        base_rx = rx_cnt; base_tx = tx_cnt;
        start_cond();
        write_byte({OWN, 1'b0}, ack);  check("rs_addr_w_ack", ack, 1);
        write_byte(8'h11, ack);        check("rs_d0_ack", ack, 1);
        write_byte(8'h22, ack);        check("rs_d1_ack", ack, 1);
        check("rs_rw_write", bus.rw, 0);
        bus.tx_data = 8'h96;
        start_cond();
        check("rs_match_clr", bus.addr_match, 0);
        check("rs_busy", bus.busy, 1);
        write_byte({OWN, 1'b1}, ack);  check("rs_addr_r_ack", ack, 1);
        check("rs_rw_read", bus.rw, 1);
        read_byte(1'b0, 8'h69, g0);    check("rs_rd0", g0, 8'h96);
        read_byte(1'b1, 8'h00, g1);    check("rs_rd1", g1, 8'h69);
        stop_cond();
        check("rs_rx_count", rx_cnt - base_rx, 2);
        check("rs_rx0", (base_rx < rx_log.size()) ? rx_log[base_rx] : 8'hXX, 8'h11);
        check("rs_rx1", (base_rx + 1 < rx_log.size()) ? rx_log[base_rx + 1] : 8'hXX, 8'h22);
        check("rs_tx_count", tx_cnt - base_tx, 2);

        // STOP after 5 bits of a data byte: nothing received, rx_data kept.
        base_rx = rx_cnt;
        start_cond();
        write_byte({OWN, 1'b0}, ack);  check("ps_addr_ack", ack, 1);
        bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r);
        bit_xfer(1'b1, r); bit_xfer(1'b0, r);
        stop_cond();
        check("ps_busy", bus.busy, 0);
        check("ps_match", bus.addr_match, 0);
        check("ps_rx_count", rx_cnt - base_rx, 0);
        check("ps_rx_data", bus.rx_data, 8'h22);

        // Reset after 4 address bits; the rest of the frame must be ignored.
        base_oe = oe_cnt;
        start_cond();
        bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b0, r);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mr_sda_oe", bus.sda_oe, 0);
        check("mr_rx_data", bus.rx_data, 8'h00);
        check("mr_addr_match", bus.addr_match, 0);
        check("mr_rw", bus.rw, 0);
        check("mr_busy", bus.busy, 0);
        bit_xfer(1'b0, r); bit_xfer(1'b0, r); bit_xfer(1'b0, r); bit_xfer(1'b0, r);
        bit_xfer(1'b1, r);
        check("mr_no_ack", r, 1);
        check("mr_busy_after", bus.busy, 0);
        check("mr_oe_never", oe_cnt - base_oe, 0);
        stop_cond();

        // A fresh START after the reset is served normally.
        rv = model(mk(OWN, 1'b0, 1, 8'h5C, 8'h00, 1'b0, 0, 8'h00, 0, 8'hFF, 8'hFF), 8'h00);
        run_xact(rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
